// File: rtl/behav_counter_ctrl.sv
// Command sequencer and round-robin arbiter sharing one up/down counter between NUM_REQ requesters.
// Drives the counter's clear/load/d/up_down each cycle and reports the resulting count with a done strobe.
//
// state | meaning
// INIT  | reset state, counter held in clear
// IDLE  | counter held, arbitrating pending requests
// EXEC  | executing captured CLEAR / LOAD / RUN command
// DONE  | one-cycle completion strobe, counter held
module behav_counter_ctrl #(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 8,
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [2*NUM_REQ-1:0]       req_op,
  input  logic [WIDTH*NUM_REQ-1:0]   req_arg,
  output logic                       done_valid,
  output logic [IW-1:0]              done_id,
  output logic [WIDTH-1:0]           done_q,
  output logic                       done_wrap,
  output logic                       busy,
  output logic                       cnt_clear,
  output logic                       cnt_load,
  output logic [WIDTH-1:0]           cnt_d,
  output logic                       cnt_up_down,
  input  logic [WIDTH-1:0]           cnt_q
);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_EXEC, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_arg;
  logic [WIDTH-1:0]   r_rem;
  logic [IW-1:0]      r_id;
  logic [IW-1:0]      r_last_grant;
  logic               r_wrap;

  logic               w_any;
  logic [IW-1:0]      w_grant;
  logic [NUM_REQ-1:0] w_onehot;
  logic [1:0]         w_op;
  logic [WIDTH-1:0]   w_arg;
  logic               w_run;
  logic               w_wrap_hit;

  // Two passes: indices above last_grant first, then wrap around from 0.
  always_comb begin
    w_any    = 1'b0;
    w_grant  = '0;
    w_onehot = '0;
    w_op     = '0;
    w_arg    = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!w_any && req_valid[j] && (IW'(j) > r_last_grant)) begin
        w_any       = 1'b1;
        w_grant     = IW'(j);
        w_onehot[j] = 1'b1;
        w_op        = req_op[2*j +: 2];
        w_arg       = req_arg[WIDTH*j +: WIDTH];
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!w_any && req_valid[j] && (IW'(j) <= r_last_grant)) begin
        w_any       = 1'b1;
        w_grant     = IW'(j);
        w_onehot[j] = 1'b1;
        w_op        = req_op[2*j +: 2];
        w_arg       = req_arg[WIDTH*j +: WIDTH];
      end
    end
  end

  assign w_run      = r_op[1];
  assign w_wrap_hit = r_op[0] ? (cnt_q == '0) : (cnt_q == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_INIT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_INIT: w_state_nxt = S_IDLE;
      S_IDLE: if (w_any) w_state_nxt = S_EXEC;
      S_EXEC: if (!w_run || (r_rem <= WIDTH'(1))) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op         <= '0;
      r_arg        <= '0;
      r_rem        <= '0;
      r_id         <= '0;
      r_last_grant <= IW'(NUM_REQ - 1);
      r_wrap       <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_op         <= w_op;
        r_arg        <= w_arg;
        r_rem        <= w_arg;
        r_id         <= w_grant;
        r_last_grant <= w_grant;
        r_wrap       <= 1'b0;
      end else if (r_state == S_EXEC && w_run && (r_rem != '0)) begin
        r_rem <= r_rem - WIDTH'(1);
        if (w_wrap_hit) r_wrap <= 1'b1;
      end
    end
  end

  // Hold is expressed as a load of the counter's own value.
  always_comb begin
    cnt_clear   = 1'b0;
    cnt_load    = 1'b0;
    cnt_d       = '0;
    cnt_up_down = 1'b0;
    req_ready   = '0;
    busy        = 1'b1;
    done_valid  = 1'b0;
    done_id     = '0;
    done_q      = '0;
    done_wrap   = 1'b0;
    case (r_state)
      S_INIT: cnt_clear = 1'b1;
      S_IDLE: begin
        busy      = 1'b0;
        cnt_load  = 1'b1;
        cnt_d     = cnt_q;
        req_ready = w_onehot;
      end
      S_EXEC: begin
        if (!w_run) begin
          if (r_op[0]) begin
            cnt_load = 1'b1;
            cnt_d    = r_arg;
          end else begin
            cnt_clear = 1'b1;
          end
        end else if (r_rem != '0) begin
          cnt_up_down = ~r_op[0];
        end else begin
          cnt_load = 1'b1;
          cnt_d    = cnt_q;
        end
      end
      S_DONE: begin
        cnt_load   = 1'b1;
        cnt_d      = cnt_q;
        done_valid = 1'b1;
        done_id    = r_id;
        done_q     = cnt_q;
        done_wrap  = r_wrap;
      end
      default: cnt_clear = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_behav_counter_ctrl.sv
// Bench for behav_counter_ctrl: models the shared counter, drives directed and random commands,
// and checks results against an arithmetic reference of count, wrap, latency and round-robin order.
module tb_behav_counter_ctrl;
  localparam int N = 4;
  localparam int W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [2*N-1:0]   req_op;
  logic [W*N-1:0]   req_arg;
  logic             done_valid;
  logic [1:0]       done_id;
  logic [W-1:0]     done_q;
  logic             done_wrap;
  logic             busy;
  logic             cnt_clear;
  logic             cnt_load;
  logic [W-1:0]     cnt_d;
  logic             cnt_up_down;
  logic [W-1:0]     cnt_q = 8'h5A;

  int n_chk  = 0;
  int n_fail = 0;
  int m_cnt;
  int m_last;
  int t_op [N];
  int t_arg[N];

  always #5 clk = ~clk;

  behav_counter_ctrl #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_arg(req_arg),
    .done_valid(done_valid), .done_id(done_id), .done_q(done_q), .done_wrap(done_wrap),
    .busy(busy), .cnt_clear(cnt_clear), .cnt_load(cnt_load), .cnt_d(cnt_d),
    .cnt_up_down(cnt_up_down), .cnt_q(cnt_q)
  );

  // Shared counter the controller sits in front of.
  always @(posedge clk) begin
    if (cnt_clear)        cnt_q <= '0;
    else if (cnt_load)    cnt_q <= cnt_d;
    else if (cnt_up_down) cnt_q <= cnt_q + 8'd1;
    else                  cnt_q <= cnt_q - 8'd1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int id, input int op, input int arg);
    req_valid[id]        = 1'b1;
    req_op[2*id +: 2]    = 2'(op);
    req_arg[W*id +: W]   = 8'(arg);
    t_op[id]             = op;
    t_arg[id]            = arg;
  endtask

  // First valid requester after the model's last grant.
  function automatic int rr_pick(input logic [N-1:0] v);
    for (int off = 1; off <= N; off++)
      if (v[(m_last + off) % N]) return (m_last + off) % N;
    return -1;
  endfunction

  task automatic wait_grant(output int g);
    int cyc = 0;
    g = -1;
    #1;
    while (req_ready == '0 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("grant_seen", 32'(req_ready != '0), 1);
    if (req_ready != '0) begin
      chk("ready_onehot", 32'($onehot(req_ready)), 1);
      for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
    end
  endtask

  // Called in the grant cycle; follows the command to DONE and back to IDLE.
  task automatic finish_cmd(input int id);
    int op = t_op[id];
    int arg = t_arg[id];
    int k, e, w, s, cyc;
    k = (op >= 2 && arg > 0) ? arg : 1;
    w = 0;
    case (op)
      0: e = 0;
      1: e = arg;
      2: begin s = m_cnt + arg; e = s % 256; w = (s > 255) ? 1 : 0; end
      default: begin s = m_cnt - arg; e = s & 255; w = (arg > m_cnt) ? 1 : 0; end
    endcase
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    cyc = 1;
    while (!done_valid && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_latency", 32'(cyc), 32'(k + 1));
    chk("done_id",      32'(done_id), 32'(id));
    chk("done_q",       32'(done_q), 32'(e));
    chk("done_wrap",    32'(done_wrap), 32'(w));
    m_cnt = e;
    @(posedge clk); #1;
    chk("back_to_idle", 32'({busy, done_valid}), 0);
  endtask

  task automatic do_cmd(input int id, input int op, input int arg);
    int g;
    set_req(id, op, arg);
    wait_grant(g);
    chk("grant_id", 32'(g), 32'(id));
    m_last = id;
    finish_cmd(id);
  endtask

  initial begin
    int g, a, b, wexp, prev, grants, cyc, saw_done;
    rst_n     = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_arg   = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cnt_clear", 32'(cnt_clear), 1);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_cnt_ctl", 32'({cnt_load, cnt_d, cnt_up_down}), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_done", 32'({done_valid, done_id, done_q, done_wrap}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_cnt_q", 32'(cnt_q), 0);
    chk("idle_hold_load", 32'(cnt_load), 1);
    m_cnt  = 0;
    m_last = N - 1;

    do_cmd(2, 1, 8'h10);
    do_cmd(2, 2, 5);
    do_cmd(1, 1, 8'h02);
    do_cmd(1, 3, 4);
    do_cmd(0, 1, 8'hFE);
    do_cmd(0, 2, 3);

    do_cmd(0, 1, 8'hA5);
    for (int i = 0; i < 50; i++) begin
      chk("hold_cnt_q", 32'(cnt_q), 32'h0A5);
      chk("hold_cnt_load", 32'(cnt_load), 1);
      @(posedge clk); #1;
    end
    do_cmd(3, 2, 0);

    // All requesters valid with CLEAR: expect strict rotation, 3 cycles apart.
    for (int i = 0; i < N; i++) set_req(i, 0, 0);
    #1;
    prev = -1; grants = 0; cyc = 0;
    while (grants < 5 && cyc < 60) begin
      if (req_ready != '0) begin
        chk("rr_onehot", 32'($onehot(req_ready)), 1);
        wexp = rr_pick(req_valid);
        chk("rr_order", 32'(req_ready), 32'(1 << wexp));
        if (prev >= 0) chk("rr_spacing", 32'(cyc - prev), 3);
        prev = cyc;
        m_last = wexp;
        grants++;
      end
      if (grants < 5) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("rr_grants", 32'(grants), 5);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    m_cnt = 0;
    chk("rr_cnt_q", 32'(cnt_q), 0);

    // Random commands, sometimes two requesters contending.
    for (int it = 0; it < 30; it++) begin
      a = $urandom_range(0, N - 1);
      b = $urandom_range(0, N - 1);
      set_req(a, $urandom_range(0, 3), $urandom_range(0, 255));
      if (b != a) set_req(b, $urandom_range(0, 3), $urandom_range(0, 255));
      wexp = rr_pick(req_valid);
      wait_grant(g);
      chk("rand_grant", 32'(g), 32'(wexp));
      m_last = wexp;
      finish_cmd(wexp);
      if (b != a) begin
        wexp = (wexp == a) ? b : a;
        wait_grant(g);
        chk("rand_grant2", 32'(g), 32'(wexp));
        m_last = wexp;
        finish_cmd(wexp);
      end
    end

    // Reset in the middle of a long RUN_UP.
    do_cmd(2, 0, 0);
    set_req(2, 2, 100);
    wait_grant(g);
    @(posedge clk); #1;
    req_valid = '0;
    saw_done = 0;
    repeat (19) begin
      @(posedge clk); #1;
      if (done_valid) saw_done = 1;
    end
    chk("midrun_cnt_q", 32'(cnt_q), 19);
    rst_n = 1'b0;
    #1;
    chk("midrun_clear", 32'(cnt_clear), 1);
    chk("midrun_busy", 32'(busy), 1);
    repeat (2) begin
      @(posedge clk); #1;
      if (done_valid) saw_done = 1;
    end
    chk("midrun_cnt_zero", 32'(cnt_q), 0);
    rst_n = 1'b1;
    m_cnt = 0;
    m_last = N - 1;
    set_req(0, 1, 8'h33);
    set_req(3, 1, 8'h44);
    @(posedge clk);
    wait_grant(g);
    chk("rearb_first", 32'(g), 0);
    m_last = 0;
    finish_cmd(0);
    wait_grant(g);
    chk("rearb_second", 32'(g), 3);
    m_last = 3;
    finish_cmd(3);
    chk("midrun_no_done", 32'(saw_done), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/behav_counter_ctrl.md
# behav_counter_ctrl

Command sequencer and round-robin arbiter that shares one `behav_counter` instance between `NUM_REQ` requesters. It accepts CLEAR, LOAD and RUN-up/down commands, drives the counter's `clear`/`load`/`d`/`up_down` inputs cycle by cycle, and returns the resulting count with a completion strobe. It sits directly in front of the counter. The counter's `qd` output feeds back into `cnt_q`.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 8: counter width; must match the counter's `d`/`qd` width.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in NUM_REQ: per-requester command valid.
- `req_ready` out NUM_REQ: one-hot grant/accept.
- `req_op` in 2*NUM_REQ: per-requester op (requester i at bits 2i+1:2i). 00 CLEAR, 01 LOAD, 10 RUN_UP, 11 RUN_DOWN.
- `req_arg` in WIDTH*NUM_REQ: per-requester argument. LOAD value, or RUN step count.
- `done_valid` out 1: one-cycle completion strobe.
- `done_id` out clog2(NUM_REQ): index of the requester whose command completed.
- `done_q` out WIDTH: counter value after the command.
- `done_wrap` out 1: the RUN crossed the wrap boundary at least once.
- `busy` out 1: high in every state except IDLE.
- `cnt_clear` out 1: to counter `clear`.
- `cnt_load` out 1: to counter `load`.
- `cnt_d` out WIDTH: to counter `d`.
- `cnt_up_down` out 1: to counter `up_down`; 1 = up.
- `cnt_q` in WIDTH: from counter `qd`.

## Operation
- Counter contract, per rising edge, in priority order:
  - `clear` → 0.
  - else `load` → `d`.
  - else ±1 per `up_down`, modulo 2^WIDTH.
- Hold is implemented as `cnt_load`=1 with `cnt_d`=`cnt_q`.
- FSM states: INIT, IDLE, EXEC, DONE. State, captured op/arg/id, remaining-steps counter and wrap flag are registers. `cnt_*`, `req_ready` and `busy` decode combinationally from these registers plus `req_valid`/`cnt_q`.
- **INIT** (reset state):
  - Drives `cnt_clear`=1.
  - Goes to IDLE on the first clock after `rst_n` deasserts.
- **IDLE**:
  - Holds the counter.
  - If any `req_valid` is set, grants the first valid index after `last_grant`, round-robin with wrap to 0.
  - Asserts `req_ready[g]` in the same cycle.
  - Captures op, arg and g; updates `last_grant`=g; clears the wrap flag; goes to EXEC.
  - If no `req_valid` is set, stays in IDLE.
- **EXEC**, by captured op:
  - CLEAR: `cnt_clear`=1 for 1 cycle, then DONE.
  - LOAD: `cnt_load`=1, `cnt_d`=arg for 1 cycle, then DONE.
  - RUN with arg=n≥1:
    - Drives `cnt_clear`=0, `cnt_load`=0, `cnt_up_down`=op[0] inverted (RUN_UP→1) for exactly n cycles.
    - The remaining counter loads n at grant and decrements each EXEC cycle; exit to DONE when it is 1.
    - The wrap flag sets when a step is taken with `cnt_q`=all-ones (up) or 0 (down).
  - RUN with arg=0: holds for 1 cycle, then DONE; counter unchanged.
- **DONE**:
  - Holds the counter.
  - `done_valid`=1, `done_id`=captured id, `done_q`=`cnt_q`, `done_wrap`=wrap flag (wrap is 0 for CLEAR/LOAD).
  - Goes to IDLE next cycle.
- Arithmetic is modulo 2^WIDTH; no saturation.
- Requests stay pending while the FSM is not in IDLE. `req_valid` must be held until `req_ready`. `req_op`/`req_arg` are sampled only in the grant cycle.

## Timing
- Reset values:
  - State=INIT, `last_grant`=NUM_REQ-1, so requester 0 wins first.
  - `cnt_clear`=1; `cnt_load`=0, `cnt_d`=0, `cnt_up_down`=0.
  - `req_ready`=0, `busy`=1.
  - `done_valid`=0, `done_id`=0, `done_q`=0, `done_wrap`=0.
- Grant in cycle T (IDLE). EXEC occupies T+1..T+k, where k=max(n,1) for RUN and k=1 otherwise. `done_valid` is high at T+k+1. The earliest next grant is T+k+2.
- Back-to-back throughput is 1 command per k+2 cycles.
- `rst_n` asserted mid-command:
  - Immediately enters INIT and drives `cnt_clear`=1.
  - The command is dropped; no `done_valid` is issued.
  - Pending requests are re-arbitrated from requester 0.
- When all requesters are valid continuously, each is granted once per NUM_REQ grants.

## Test plan
- Reset: hold `rst_n`=0 → `cnt_clear`=1, `busy`=1, all other outputs 0. Release → first clock IDLE, counter reads 0, `busy`=0.
- LOAD then RUN_UP:
  - Requester 2 issues LOAD 8'h10 → `done_q`=8'h10, `done_id`=2, `done_valid` 2 cycles after grant.
  - Then RUN_UP n=5 → `done_q`=8'h15, `done_wrap`=0, `done_valid` 6 cycles after grant.
- Wrap down: LOAD 8'h02, then RUN_DOWN n=4 → `done_q`=8'hFE, `done_wrap`=1. Also: RUN_UP n=0 → `done_q` unchanged, k=1.
- Round-robin: all 4 `req_valid` held high with CLEAR ops → grants in order 0,1,2,3,0. Each `req_ready` is one-hot and high for exactly 1 cycle. Grants are spaced 3 cycles apart.
- Reset mid-RUN: RUN_UP n=100 from 0, assert `rst_n`=0 after 20 EXEC cycles → no `done_valid`, `cnt_clear`=1 immediately, counter returns to 0.
- Hold check: idle for 50 cycles after LOAD 8'hA5 → `cnt_q` stays 8'hA5 and `cnt_load`=1 throughout.
